ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
Instruction-fetch front end that produces the 32-bit instruction word consumed by the decode stage, together with its PC. It owns the fetch PC, issues requests to a synchronous instruction memory, buffers returned words in a small FIFO, and presents them to ID with a valid/ready handshake. Redirects from branch/JAL/JALR resolution flush all wrong-path state.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset (bits[1:0] must be 0)
DEPTH, 2, fetch FIFO entries; power of 2, >= 2

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request this cycle
imem_addr  output  32  fetch address; equals current fetch PC
imem_rdata  input  32  instruction word; valid exactly 1 cycle after an accepted imem_req, never stalls
redirect  input  1  control-flow change resolved downstream
redirect_target  input  32  new fetch PC when redirect=1
id_valid  output  1  Instruction/id_pc hold a valid entry
id_ready  input  1  decode accepts the entry this cycle
Instruction  output  32  instruction word to decode
id_pc  output  32  PC of Instruction
id_pc_plus4  output  32  id_pc + 4, for JAL/JALR link

Behaviour:
- Reset: pc_f=RESET_PC, FIFO count=0, in-flight flag=0, imem_req=0, id_valid=0, Instruction=32'h0000_0013 (NOP), id_pc=RESET_PC, id_pc_plus4=RESET_PC+4. Reset overrides redirect and the handshake; takes effect at the next edge even mid-stream.
- Pop: pop = id_valid && id_ready && !redirect. Output is the FIFO head; id_valid = (count != 0). When count=0, Instruction = NOP and id_pc holds its last value.
- Issue: imem_req = !reset && !redirect && (count + inflight - pop) < DEPTH. This deliberately includes a combinational path from id_ready to imem_req. On an issue, pc_f <= pc_f + 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0), inflight <= 1, and the issuing PC is recorded. Without an issue, inflight <= 0.
- Capture: when inflight=1 and no redirect occurs in that cycle, {imem_rdata, recorded PC} is pushed at the cycle-end edge.
- Push and pop in the same cycle are both allowed, including when count=DEPTH. The credit rule guarantees no push occurs when the FIFO is full and no pop happens. Overflow is impossible by construction; bench asserts it.
- Latency: request in cycle N, data in N+1, id_valid=1 in N+2. Steady state is 1 instruction/cycle with id_ready held high.
- Redirect (highest priority after reset):
  - At the edge: pc_f <= {redirect_target[31:2], 2'b00}; FIFO count <= 0; inflight <= 0.
  - Any response arriving in the redirect cycle is discarded; the handshake in that cycle is void.
  - No request is issued in the redirect cycle. The target is requested in the next cycle, and the first target instruction has id_valid=1 two cycles after that (redirect penalty = 3 cycles).
- Back-to-back redirects: the latest one wins; each restarts the sequence above.
- id_ready low: outputs are held stable while id_valid=1. At most DEPTH outstanding (buffered + in flight) at any time.

Test Plan:
1. Release reset with RESET_PC=0, imem returning addr|0xA000_0000, id_ready=1 -> requests at 0,4,8,... on consecutive cycles; id_valid rises 2 cycles after release; Instruction/id_pc pairs 0xA000_0000/0, 0xA000_0004/4, ... with no gaps; id_pc_plus4 = id_pc+4.
2. Stream, then id_ready=0 for 6 cycles -> exactly 2 entries buffered, imem_req=0 once full, outputs stable; on id_ready=1 the sequence resumes with no word lost or duplicated.
3. Redirect with target 0x100 while one response is in flight -> wrong-path word is never presented, id_valid=0 for 2 cycles, next presented entry has id_pc=0x100, then 0x104.
4. Redirect with target 0x0000_0103 -> fetch resumes at 0x100; also a redirect in consecutive cycles (0x200 then 0x300) -> first presented id_pc=0x300.
5. Assert reset mid-stream with count=2 -> next cycle id_valid=0, Instruction=0x0000_0013, imem_req=0; after release, fetch restarts at RESET_PC.
6. RESET_PC=0xFFFF_FFF8, id_ready=1 -> id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; id_pc_plus4 for FFFF_FFFC equals 0.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// Fetch-side bundle: instruction memory port, redirect and ID handshake.
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] Instruction;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  redirect, redirect_target,
        output id_valid, Instruction, id_pc, id_pc_plus4,
        input  id_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output redirect, redirect_target,
        input  id_valid, Instruction, id_pc, id_pc_plus4,
        output id_ready
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: fetch PC, one-deep request pipe and a
// credit-limited FIFO feeding decode over a valid/ready handshake.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic           clk,
    input logic           reset,
    ifetch_unit_if.master bus
);
    localparam int          PW  = $clog2(DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   last_pc_q;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   dpc_q  [DEPTH];

    logic        valid, pop, push, issue;
    logic [CW:0] occ;
    logic [31:0] instr, cur_pc;

    always_comb begin
        valid  = (count_q != '0);
        instr  = valid ? data_q[rd_q] : NOP;
        cur_pc = valid ? dpc_q[rd_q] : last_pc_q;
        pop    = valid && bus.id_ready && !bus.redirect;
        push   = inflight_q && !bus.redirect;
        // Credit check counts the word in flight and a slot freed by pop.
        occ    = {1'b0, count_q}
               + {{CW{1'b0}}, inflight_q}
               - {{CW{1'b0}}, pop};
        issue  = !reset && !bus.redirect && (occ < (CW+1)'(DEPTH));
    end

    assign bus.id_valid    = valid;
    assign bus.Instruction = instr;
    assign bus.id_pc       = cur_pc;
    assign bus.id_pc_plus4 = cur_pc + 32'd4;
    assign bus.imem_req    = issue;
    assign bus.imem_addr   = pc_q;

    always_comb begin
        pc_d       = pc_q;
        inflight_d = issue;
        req_pc_d   = req_pc_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        count_d    = count_q;
        if (bus.redirect) begin
            pc_d       = {bus.redirect_target[31:2], 2'b00};
            inflight_d = 1'b0;
            rd_d       = '0;
            wr_d       = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                pc_d     = pc_q + 32'd4;
                req_pc_d = pc_q;
            end
            if (pop) rd_d = rd_q + PW'(1);
            if (push) wr_d = wr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            req_pc_q   <= RESET_PC;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            last_pc_q  <= RESET_PC;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            req_pc_q   <= req_pc_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            last_pc_q  <= cur_pc;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_q] <= bus.imem_rdata;
            dpc_q[wr_q]  <= req_pc_q;
        end
    end
endmodule
